// File: rtl/ahb_response_mux_master.sv
// AHB master-side return path: data-phase slave select, response mux and
// built-in default slave that answers unmapped accesses with a 2-cycle ERROR.
//
// Ports:
//   hclk, hreset      bus clock (rising edge), async active-high reset
//   hreq              decoder address-phase slave request (may be multi-hot)
//   default_slv_sel   decoder flag: unmapped non-IDLE access
//   hrdata_s          per-slave read data, packed [NUM-1:0][W-1:0]
//   hreadyout_s       per-slave hreadyout
//   hresp_s           per-slave hresp (0 OKAY, 1 ERROR)
//   hrdata            read data to master
//   hready            transfer done / address phase accepted
//   hresp             response to master
//   data_sel          registered one-hot data-phase slave select
//   err_cnt           saturating count of default-slave errors
module ahb_response_mux_master #(
  parameter int AHB_DATA_WIDTH     = 32,
  parameter int MASTER_X_SLAVE_NUM = 2,
  parameter int ERR_CNT_WIDTH      = 8
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [MASTER_X_SLAVE_NUM-1:0]
                                    hreq,
  input  logic                      default_slv_sel,
  input  logic [MASTER_X_SLAVE_NUM-1:0][AHB_DATA_WIDTH-1:0]
                                    hrdata_s,
  input  logic [MASTER_X_SLAVE_NUM-1:0]
                                    hreadyout_s,
  input  logic [MASTER_X_SLAVE_NUM-1:0]
                                    hresp_s,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  output logic                      hready,
  output logic                      hresp,
  output logic [MASTER_X_SLAVE_NUM-1:0]
                                    data_sel,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

  localparam int N = MASTER_X_SLAVE_NUM;
  localparam int W = AHB_DATA_WIDTH;

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [N-1:0]             data_sel_q, data_sel_d;
  logic [1:0]               ds_state_q, ds_state_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [N-1:0] req_oh;
  logic         capture;
  logic         err_enter;

  // Lowest-index request wins when the decoder asserts several bits.
  always_comb begin
    req_oh = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hreq[i]) begin
        req_oh    = '0;
        req_oh[i] = 1'b1;
      end
    end
  end

  assign capture = hready;

  always_comb begin
    data_sel_d = data_sel_q;
    if (capture) begin
      data_sel_d = default_slv_sel ? '0 : req_oh;
    end
  end

  // ERR1 always drives hready low, so capture never fires there.
  always_comb begin
    ds_state_d = DS_IDLE;
    case (ds_state_q)
      DS_IDLE: begin
        if (capture && default_slv_sel) ds_state_d = DS_ERR1;
      end
      DS_ERR1: ds_state_d = DS_ERR2;
      DS_ERR2: begin
        if (capture && default_slv_sel) ds_state_d = DS_ERR1;
      end
      default: ds_state_d = DS_IDLE;
    endcase
  end

  assign err_enter = (ds_state_d == DS_ERR1) &&
                     (ds_state_q != DS_ERR1);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_enter && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      data_sel_q <= '0;
      ds_state_q <= DS_IDLE;
      err_cnt_q  <= '0;
    end else begin
      data_sel_q <= data_sel_d;
      ds_state_q <= ds_state_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Masked AND-OR mux: an unselected slave's inputs are forced to zero
  // before merging, so X on an idle slave cannot reach the master.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    if (|data_sel_q) begin
      hready = 1'b0;
      for (int i = 0; i < N; i++) begin
        hrdata = hrdata | (hrdata_s[i] & {W{data_sel_q[i]}});
        hready = hready | (hreadyout_s[i] & data_sel_q[i]);
        hresp  = hresp  | (hresp_s[i] & data_sel_q[i]);
      end
    end else begin
      case (ds_state_q)
        DS_ERR1: begin
          hready = 1'b0;
          hresp  = 1'b1;
        end
        DS_ERR2: begin
          hready = 1'b1;
          hresp  = 1'b1;
        end
        default: begin
          hready = 1'b1;
          hresp  = 1'b0;
        end
      endcase
    end
  end

  assign data_sel = data_sel_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ahb_response_mux_master.sv
// Self-checking bench for ahb_response_mux_master.
// Per-cycle expectations go through a scoreboard queue.
module tb_ahb_response_mux_master;

  logic             hclk;
  logic             hreset;
  logic [1:0]       hreq;
  logic             default_slv_sel;
  logic [1:0][31:0] hrdata_s;
  logic [1:0]       hreadyout_s;
  logic [1:0]       hresp_s;
  logic [31:0]      hrdata;
  logic             hready;
  logic             hresp;
  logic [1:0]       data_sel;
  logic [7:0]       err_cnt;

  typedef struct packed {
    logic        rdy;
    logic        rsp;
    logic [31:0] rd;
    logic [1:0]  sel;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  ahb_response_mux_master #(
    .AHB_DATA_WIDTH(32),
    .MASTER_X_SLAVE_NUM(2),
    .ERR_CNT_WIDTH(8)
  ) dut (
    .hclk(hclk),
    .hreset(hreset),
    .hreq(hreq),
    .default_slv_sel(default_slv_sel),
    .hrdata_s(hrdata_s),
    .hreadyout_s(hreadyout_s),
    .hresp_s(hresp_s),
    .hrdata(hrdata),
    .hready(hready),
    .hresp(hresp),
    .data_sel(data_sel),
    .err_cnt(err_cnt)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic rdy, input logic rsp,
                              input logic [31:0] rd,
                              input logic [1:0] sel);
    exp_t e;
    e.rdy = rdy;
    e.rsp = rsp;
    e.rd  = rd;
    e.sel = sel;
    e.cnt = 8'(exp_cnt);
    return e;
  endfunction

  // Drive one cycle of inputs, queue what the master must see in this
  // data phase, compare, then advance past the next rising edge.
  task automatic step(input string tag,
                      input logic [1:0] req, input logic dsel,
                      input logic [1:0] rdy_s, input logic [1:0] rsp_s,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input exp_t e);
    exp_t g;
    hreq            = req;
    default_slv_sel = dsel;
    hreadyout_s     = rdy_s;
    hresp_s         = rsp_s;
    hrdata_s[0]     = d0;
    hrdata_s[1]     = d1;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk({tag, ".hready"}, 64'(hready), 64'(g.rdy));
    chk({tag, ".hresp"}, 64'(hresp), 64'(g.rsp));
    chk({tag, ".hrdata"}, 64'(hrdata), 64'(g.rd));
    chk({tag, ".data_sel"}, 64'(data_sel), 64'(g.sel));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(g.cnt));
    @(posedge hclk);
    #1;
  endtask

  function automatic void bump();
    if (exp_cnt < 255) exp_cnt++;
  endfunction

  initial begin
    hreset          = 1'b1;
    hreq            = '0;
    default_slv_sel = 1'b0;
    hrdata_s        = '0;
    hreadyout_s     = 2'b11;
    hresp_s         = '0;
    @(posedge hclk);
    #1;
    chk("rst.hready", 64'(hready), 64'd1);
    chk("rst.hresp", 64'(hresp), 64'd0);
    chk("rst.hrdata", 64'(hrdata), 64'd0);
    chk("rst.data_sel", 64'(data_sel), 64'd0);
    chk("rst.err_cnt", 64'(err_cnt), 64'd0);
    hreset = 1'b0;

    // Slave 0 read with two wait states.
    step("t2a", 2'b01, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));
    step("t2b", 2'b00, 0, 2'b10, 2'b00, 32'h1111_0000, 32'h0,
         mk(0, 0, 32'h1111_0000, 2'b01));
    step("t2c", 2'b00, 0, 2'b10, 2'b00, 32'h2222_0000, 32'h0,
         mk(0, 0, 32'h2222_0000, 2'b01));
    step("t2d", 2'b00, 0, 2'b11, 2'b00, 32'hDEAD_BEEF, 32'h0,
         mk(1, 0, 32'hDEAD_BEEF, 2'b01));
    step("t2e", 2'b00, 0, 2'b11, 2'b00, 32'h5555_5555, 32'h0,
         mk(1, 0, 32'h0, 2'b00));

    // Single decode error; hreq during ERR1 must not be captured.
    step("t3a", 2'b00, 1, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));
    bump();
    step("t3b", 2'b01, 0, 2'b11, 2'b00, 32'hAAAA_AAAA, 32'h0,
         mk(0, 1, 32'h0, 2'b00));
    step("t3c", 2'b00, 0, 2'b11, 2'b00, 32'hAAAA_AAAA, 32'h0,
         mk(1, 1, 32'h0, 2'b00));
    step("t3d", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));

    // Back-to-back decode errors.
    step("t4a", 2'b00, 1, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));
    bump();
    step("t4b", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(0, 1, 32'h0, 2'b00));
    step("t4c", 2'b00, 1, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 1, 32'h0, 2'b00));
    bump();
    step("t4d", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(0, 1, 32'h0, 2'b00));
    step("t4e", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 1, 32'h0, 2'b00));
    step("t4f", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));

    // Multi-hot request, slave 1 noise ignored, deferred capture.
    step("t5a", 2'b11, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));
    step("t5b", 2'b10, 0, 2'b00, 2'b10, 32'h1234_5678, 32'hFFFF_FFFF,
         mk(0, 0, 32'h1234_5678, 2'b01));
    step("t5c", 2'b10, 0, 2'b00, 2'b10, 32'h1234_5678, 32'hFFFF_FFFF,
         mk(0, 0, 32'h1234_5678, 2'b01));
    step("t5d", 2'b10, 0, 2'b01, 2'b10, 32'h0BAD_F00D, 32'hFFFF_FFFF,
         mk(1, 0, 32'h0BAD_F00D, 2'b01));
    step("t5e", 2'b00, 0, 2'b10, 2'b00, 32'hxxxx_xxxx, 32'hCAFE_0001,
         mk(1, 0, 32'hCAFE_0001, 2'b10));
    // Slave ERROR passes straight through.
    step("t5f", 2'b10, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));
    step("t5g", 2'b00, 0, 2'b01, 2'b10, 32'h0, 32'h0,
         mk(0, 1, 32'h0, 2'b10));
    step("t5h", 2'b00, 0, 2'b11, 2'b10, 32'h0, 32'h0,
         mk(1, 1, 32'h0, 2'b10));
    step("t5i", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));

    // 300 consecutive decode errors: counter must saturate.
    for (int k = 0; k < 600; k++) begin
      if (k == 0) begin
        step("t6", 2'b00, 1, 2'b11, 2'b00, 32'h0, 32'h0,
             mk(1, 0, 32'h0, 2'b00));
        bump();
      end else if (k % 2 == 1) begin
        step("t6", 2'b00, 1, 2'b11, 2'b00, 32'h0, 32'h0,
             mk(0, 1, 32'h0, 2'b00));
      end else begin
        step("t6", 2'b00, 1, 2'b11, 2'b00, 32'h0, 32'h0,
             mk(1, 1, 32'h0, 2'b00));
        bump();
      end
    end
    step("t6y", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 1, 32'h0, 2'b00));
    step("t6z", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));
    chk("t6.sat", 64'(err_cnt), 64'hFF);

    // Async reset while the default slave sits in ERR1.
    step("t1a", 2'b00, 1, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));
    chk("t1.in_err1", 64'(hready), 64'd0);
    #2;
    hreset = 1'b1;
    #1;
    chk("t1.hready", 64'(hready), 64'd1);
    chk("t1.hresp", 64'(hresp), 64'd0);
    chk("t1.err_cnt", 64'(err_cnt), 64'd0);
    chk("t1.data_sel", 64'(data_sel), 64'd0);
    @(posedge hclk);
    #1;
    hreset  = 1'b0;
    exp_cnt = 0;
    step("t1b", 2'b00, 0, 2'b11, 2'b00, 32'h0, 32'h0,
         mk(1, 0, 32'h0, 2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
